// File: rtl/apb_pkg.sv
// Shared APB constants: bus widths and the state encoding used by the bridge and its completers.
package apb_pkg;

    localparam int unsigned APB_DW = 8;
    localparam int unsigned APB_AW = 9;
    localparam int unsigned SLV_AW = 8;

    localparam logic [2:0] IDLE   = 3'b001;
    localparam logic [2:0] SETUP  = 3'b010;
    localparam logic [2:0] ENABLE = 3'b100;

    // The completer's access state reuses the SETUP code so bus traces line up with the bridge.
    localparam logic [2:0] ACCESS = SETUP;

endpackage

// File: rtl/apb_mem_array.sv
// DEPTH x 8 register-file storage: synchronous write, synchronous clear, combinational read.
module apb_mem_array
    import apb_pkg::*;
#(
    parameter int unsigned DEPTH = 256
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              we_i,
    input  logic [SLV_AW-1:0] waddr_i,
    input  logic [APB_DW-1:0] wdata_i,
    input  logic [SLV_AW-1:0] raddr_i,
    output logic [APB_DW-1:0] rdata_o
);

    localparam int unsigned IdxW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [8:0]  DepthLim = 9'(DEPTH);

    logic [APB_DW-1:0] mem_q [DEPTH];
    logic              waddr_ok;
    logic              raddr_ok;

    // Range guards keep non-power-of-two depths from indexing past the array.
    always_comb begin
        waddr_ok = ({1'b0, waddr_i} < DepthLim);
        raddr_ok = ({1'b0, raddr_i} < DepthLim);
        rdata_o  = raddr_ok ? mem_q[raddr_i[IdxW-1:0]] : '0;
    end

    // Clear every word on reset; otherwise accept one write per cycle.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (we_i && waddr_ok) begin
            mem_q[waddr_i[IdxW-1:0]] <= wdata_i;
        end
    end

endmodule

// File: rtl/apb_slave_mem.sv
// APB completer with programmable wait states in front of a local byte memory.
module apb_slave_mem
    import apb_pkg::*;
#(
    parameter int unsigned DEPTH       = 256,
    parameter int unsigned WAIT_CYCLES = 0
) (
    input  logic              PCLK,
    input  logic              PRESET,
    input  logic              PSEL,
    input  logic              PENABLE,
    input  logic [SLV_AW-1:0] PADDR,
    input  logic              PWRITE,
    input  logic [APB_DW-1:0] PWDATA,
    output logic [APB_DW-1:0] PRDATA,
    output logic              PREADY,
    output logic              PSLVERR
);

    localparam logic [8:0] DepthLim = 9'(DEPTH);
    localparam logic [3:0] WaitLoad = 4'(WAIT_CYCLES);

    logic [2:0]        state_q, state_d;
    logic [3:0]        wcnt_q, wcnt_d;
    logic [SLV_AW-1:0] a_addr_q, a_addr_d;
    logic              a_wr_q, a_wr_d;
    logic [APB_DW-1:0] a_data_q, a_data_d;

    logic              setup_ph;
    logic              access_ph;
    logic              in_idle;
    logic              in_access;
    logic              range_err;
    logic              chg_err;
    logic              err;
    logic              xfer_ready;
    logic              proto_err;
    logic              mem_we;
    logic [APB_DW-1:0] mem_rdata;

    // Response decode: all outputs are combinational from registered state plus live bus inputs.
    always_comb begin
        setup_ph   = PSEL & ~PENABLE;
        access_ph  = PSEL & PENABLE;
        in_idle    = (state_q == IDLE);
        in_access  = (state_q == ACCESS);
        range_err  = ({1'b0, a_addr_q} >= DepthLim);
        // Bus must hold address/direction/write data stable from setup through access.
        chg_err    = (PADDR != a_addr_q) | (PWRITE != a_wr_q) | (a_wr_q & (PWDATA != a_data_q));
        err        = range_err | chg_err;
        xfer_ready = in_access & access_ph & (wcnt_q == 4'd0);
        // Access phase with no preceding setup is answered immediately with an error.
        proto_err  = in_idle & access_ph;
        PREADY     = xfer_ready | proto_err;
        PSLVERR    = (xfer_ready & err) | proto_err;
        PRDATA     = (in_access & ~a_wr_q & ~err) ? mem_rdata : '0;
        mem_we     = xfer_ready & a_wr_q & ~err;
    end

    // Next-state: latch setup, count wait states, return to IDLE on completion or abort.
    always_comb begin
        state_d  = state_q;
        wcnt_d   = wcnt_q;
        a_addr_d = a_addr_q;
        a_wr_d   = a_wr_q;
        a_data_d = a_data_q;
        case (state_q)
            IDLE: begin
                if (setup_ph) begin
                    state_d  = ACCESS;
                    wcnt_d   = WaitLoad;
                    a_addr_d = PADDR;
                    a_wr_d   = PWRITE;
                    a_data_d = PWDATA;
                end
            end
            ACCESS: begin
                if (!PSEL) begin
                    state_d = IDLE;
                end else if (PENABLE) begin
                    if (wcnt_q == 4'd0) begin
                        state_d = IDLE;
                    end else begin
                        wcnt_d = wcnt_q - 4'd1;
                    end
                end else begin
                    // A fresh setup restarts the transfer with new latches.
                    wcnt_d   = WaitLoad;
                    a_addr_d = PADDR;
                    a_wr_d   = PWRITE;
                    a_data_d = PWDATA;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State registers with synchronous active-high reset.
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state_q  <= IDLE;
            wcnt_q   <= '0;
            a_addr_q <= '0;
            a_wr_q   <= 1'b0;
            a_data_q <= '0;
        end else begin
            state_q  <= state_d;
            wcnt_q   <= wcnt_d;
            a_addr_q <= a_addr_d;
            a_wr_q   <= a_wr_d;
            a_data_q <= a_data_d;
        end
    end

    apb_mem_array #(
        .DEPTH(DEPTH)
    ) u_mem (
        .clk_i  (PCLK),
        .rst_i  (PRESET),
        .we_i   (mem_we),
        .waddr_i(a_addr_q),
        .wdata_i(a_data_q),
        .raddr_i(a_addr_q),
        .rdata_o(mem_rdata)
    );

endmodule

// File: tb/tb_apb_slave_mem.sv
// Two completers on one bus (like PSEL1/PSEL2 behind the bridge) checked against a transfer-level model.
module tb_apb_slave_mem;

    logic       PCLK = 1'b0;
    logic       PRESET;
    logic [1:0] psel;
    logic       PENABLE;
    logic [7:0] PADDR;
    logic       PWRITE;
    logic [7:0] PWDATA;
    logic [7:0] prdata  [2];
    logic       pready  [2];
    logic       pslverr [2];

    always #5 PCLK = ~PCLK;

    apb_slave_mem #(.DEPTH(256), .WAIT_CYCLES(0)) u_dut0 (
        .PCLK(PCLK), .PRESET(PRESET), .PSEL(psel[0]), .PENABLE(PENABLE), .PADDR(PADDR),
        .PWRITE(PWRITE), .PWDATA(PWDATA), .PRDATA(prdata[0]), .PREADY(pready[0]),
        .PSLVERR(pslverr[0])
    );

    apb_slave_mem #(.DEPTH(128), .WAIT_CYCLES(3)) u_dut1 (
        .PCLK(PCLK), .PRESET(PRESET), .PSEL(psel[1]), .PENABLE(PENABLE), .PADDR(PADDR),
        .PWRITE(PWRITE), .PWDATA(PWDATA), .PRDATA(prdata[1]), .PREADY(pready[1]),
        .PSLVERR(pslverr[1])
    );

    // Model: memory contents and per-slave configuration.
    int unsigned depth_m [2] = '{256, 128};
    int unsigned wait_m  [2] = '{0, 3};
    logic [7:0]  mem_m   [2][256];

    // Expected outputs for the current cycle.
    logic       exp_ready  [2];
    logic       exp_err    [2];
    logic       exp_rd_chk [2];
    logic [7:0] exp_rdata  [2];
    logic       chk_en;

    // Observations from the most recent transfer.
    logic       obs_ready;
    logic       obs_err;
    logic [7:0] obs_rdata;
    int         obs_low;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic clear_model();
        for (int d = 0; d < 2; d++) begin
            for (int a = 0; a < 256; a++) mem_m[d][a] = 8'h00;
        end
    endtask

    task automatic idle_exp();
        for (int d = 0; d < 2; d++) begin
            exp_ready[d]  = 1'b0;
            exp_err[d]    = 1'b0;
            exp_rd_chk[d] = 1'b1;
            exp_rdata[d]  = 8'h00;
        end
    endtask

    // Per-cycle compare of both slaves against the model.
    always @(negedge PCLK) begin
        if (chk_en) begin
            for (int d = 0; d < 2; d++) begin
                check($sformatf("pready%0d", d), 32'(pready[d]), 32'(exp_ready[d]));
                check($sformatf("pslverr%0d", d), 32'(pslverr[d]), 32'(exp_err[d]));
                if (exp_rd_chk[d]) check($sformatf("prdata%0d", d), 32'(prdata[d]), 32'(exp_rdata[d]));
            end
        end
    end

    // One transfer on slave d; acc_* are the values presented in the access phase.
    // rst_at >= 0 pulses PRESET during that access cycle.
    task automatic xfer(input int d, input logic wr, input logic [7:0] addr, input logic [7:0] data,
                        input logic [7:0] acc_addr, input logic [7:0] acc_data, input int rst_at);
        logic err;
        logic was_reset;
        was_reset = 1'b0;
        @(posedge PCLK); #1;
        psel    = 2'b00;
        psel[d] = 1'b1;
        PENABLE = 1'b0;
        PADDR   = addr;
        PWRITE  = wr;
        PWDATA  = data;
        idle_exp();
        @(posedge PCLK); #1;
        PENABLE = 1'b1;
        PADDR   = acc_addr;
        PWDATA  = acc_data;
        err = (32'(addr) >= depth_m[d]) || (acc_addr != addr) || (wr && (acc_data != data));
        obs_ready = 1'b0;
        obs_err   = 1'b0;
        obs_rdata = 8'h00;
        obs_low   = 0;
        for (int w = 0; w <= int'(wait_m[d]); w++) begin
            exp_ready[d]  = (w == int'(wait_m[d]));
            exp_err[d]    = exp_ready[d] && err;
            exp_rd_chk[d] = exp_ready[d];
            exp_rdata[d]  = (!wr && !err) ? mem_m[d][addr] : 8'h00;
            if (w == rst_at) PRESET = 1'b1;
            @(negedge PCLK);
            if (pready[d]) begin
                if (!obs_ready) begin
                    obs_err   = pslverr[d];
                    obs_rdata = prdata[d];
                end
                obs_ready = 1'b1;
            end else if (!obs_ready) begin
                obs_low++;
            end
            @(posedge PCLK); #1;
            if (w == rst_at) begin
                PRESET    = 1'b0;
                was_reset = 1'b1;
                clear_model();
                break;
            end
        end
        if (!was_reset && wr && !err) mem_m[d][addr] = data;
        psel    = 2'b00;
        PENABLE = 1'b0;
        idle_exp();
    endtask

    task automatic rd(input int d, input logic [7:0] addr);
        xfer(d, 1'b0, addr, 8'h00, addr, 8'h00, -1);
    endtask

    task automatic wr(input int d, input logic [7:0] addr, input logic [7:0] data);
        xfer(d, 1'b1, addr, data, addr, data, -1);
    endtask

    // Access phase straight from IDLE, without a setup cycle.
    task automatic proto_err(input int d, input logic [7:0] addr);
        @(posedge PCLK); #1;
        psel    = 2'b00;
        psel[d] = 1'b1;
        PENABLE = 1'b1;
        PADDR   = addr;
        PWRITE  = 1'b0;
        idle_exp();
        exp_ready[d] = 1'b1;
        exp_err[d]   = 1'b1;
        @(negedge PCLK);
        obs_ready = pready[d];
        obs_err   = pslverr[d];
        @(posedge PCLK); #1;
        psel    = 2'b00;
        PENABLE = 1'b0;
        idle_exp();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        PRESET  = 1'b1;
        psel    = 2'b00;
        PENABLE = 1'b0;
        PADDR   = 8'h00;
        PWRITE  = 1'b0;
        PWDATA  = 8'h00;
        chk_en  = 1'b0;
        clear_model();
        idle_exp();
        repeat (2) @(posedge PCLK);
        #1;
        PRESET = 1'b0;
        chk_en = 1'b1;
        @(negedge PCLK);
        check("rst_pready1", 32'(pready[1]), 32'd0);
        check("rst_prdata1", 32'(prdata[1]), 32'd0);

        // Zero-wait write then read.
        wr(0, 8'h10, 8'hA5);
        check("w0_ready", 32'(obs_ready), 32'd1);
        check("w0_low", 32'(obs_low), 32'd0);
        check("w0_err", 32'(obs_err), 32'd0);
        rd(0, 8'h10);
        check("r0_data", 32'(obs_rdata), 32'hA5);

        // Three wait states.
        wr(1, 8'h20, 8'h3C);
        rd(1, 8'h20);
        check("ws_data", 32'(obs_rdata), 32'h3C);
        check("ws_low", 32'(obs_low), 32'd3);
        check("ws_len", 32'(2 + obs_low), 32'd5);

        // Out of range on the 128-deep slave; aliased in-range word untouched.
        wr(1, 8'h10, 8'h11);
        wr(1, 8'h90, 8'hFF);
        check("oor_ready", 32'(obs_ready), 32'd1);
        check("oor_err", 32'(obs_err), 32'd1);
        rd(1, 8'h10);
        check("oor_alias", 32'(obs_rdata), 32'h11);
        wr(0, 8'h90, 8'hFF);
        check("inr_err", 32'(obs_err), 32'd0);

        // Protocol error, then a normal read.
        proto_err(0, 8'h10);
        check("proto_ready", 32'(obs_ready), 32'd1);
        check("proto_err", 32'(obs_err), 32'd1);
        rd(0, 8'h10);
        check("proto_next_err", 32'(obs_err), 32'd0);
        check("proto_next_data", 32'(obs_rdata), 32'hA5);

        // Address changes between setup and access.
        xfer(0, 1'b1, 8'h05, 8'h77, 8'h06, 8'h77, -1);
        check("chg_err", 32'(obs_err), 32'd1);
        rd(0, 8'h05);
        check("chg_a05", 32'(obs_rdata), 32'h00);
        rd(0, 8'h06);
        check("chg_a06", 32'(obs_rdata), 32'h00);

        // Reset in the second wait cycle of a write.
        xfer(1, 1'b1, 8'h30, 8'h5A, 8'h30, 8'h5A, 1);
        @(negedge PCLK);
        check("rst_mid_ready", 32'(pready[1]), 32'd0);
        check("rst_mid_err", 32'(pslverr[1]), 32'd0);
        check("rst_mid_data", 32'(prdata[1]), 32'd0);
        rd(1, 8'h30);
        check("rst_tgt", 32'(obs_rdata), 32'h00);
        rd(1, 8'h20);
        check("rst_clr1", 32'(obs_rdata), 32'h00);
        rd(0, 8'h10);
        check("rst_clr0", 32'(obs_rdata), 32'h00);

        @(posedge PCLK); #1;
        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/apb_slave_mem.md
# apb_slave_mem

APB completer (slave) that sits directly downstream of the two-slave APB master bridge: one instance is wired to PSEL1, a second to PSEL2. It decodes one transfer at a time, inserts a programmable number of wait states, and services byte reads/writes to a local register-file memory. It reports PSLVERR on out-of-range addresses and on protocol violations.

## Interface
- DEPTH, 256: number of 8-bit words implemented, 1..256; addresses >= DEPTH are out of range.
- WAIT_CYCLES, 0: PREADY-low cycles inserted per access, 0..15.
- PCLK  in  1  clock; all state changes on rising edge.
- PRESET  in  1  reset; synchronous, active-high (one clock; reset is synchronous and active-high).
- PSEL  in  1  slave select from the bridge (PSEL1 or PSEL2).
- PENABLE  in  1  APB access phase.
- PADDR  in  8  word address; bridge PADDR[7:0], since bit 8 is consumed by the bridge decode.
- PWRITE  in  1  1 = write, 0 = read.
- PWDATA  in  8  write data.
- PRDATA  out  8  read data; valid when PREADY=1 on a read.
- PREADY  out  1  transfer completes this cycle.
- PSLVERR  out  1  error response; meaningful only when PREADY=1.

## Operation
- FSM states, one-hot 3-bit:
  - IDLE: no transfer.
  - ACCESS: setup latched, counting wait states.
  - DONE: not used; the state encoding reserves it.
- IDLE -> ACCESS on an edge sampling PSEL=1, PENABLE=0. At that edge, latch PADDR, PWRITE, PWDATA into a_addr, a_wr, a_data, and load wcnt=WAIT_CYCLES.
- In ACCESS, while wcnt!=0, each edge with PSEL&PENABLE decrements wcnt.
- PREADY = (state==ACCESS) & PSEL & PENABLE & (wcnt==0). This is combinational from registered state. With WAIT_CYCLES=0 it is a zero-wait response.
- Completion edge is PSEL&PENABLE&PREADY:
  - If no error and a_wr=1: write mem[a_addr] <= a_data.
  - Next state is IDLE.
  - If the same edge also samples PSEL=1, PENABLE=0 (back-to-back setup), go straight to ACCESS with new latches instead.
- PRDATA = mem[a_addr] when in ACCESS and a_wr=0, else 8'h00.
- PSLVERR = PREADY & err, where err is the OR of:
  - a_addr >= DEPTH;
  - in ACCESS, PADDR!=a_addr or PWRITE!=a_wr, or (a_wr & PWDATA!=a_data). Inputs changed between setup and access.
- An erroring write does not modify memory. An erroring read returns PRDATA=8'h00.
- Protocol error: PSEL=1, PENABLE=1 while in IDLE (no setup seen).
  - Respond PREADY=1, PSLVERR=1 for that cycle.
  - No memory access; state stays IDLE.
- PSEL deasserted while in ACCESS: abort to IDLE next edge; no write; PREADY stays 0.

## Timing
- Reset (PRESET=1 at an edge):
  - state=IDLE, wcnt=0, a_addr=0, a_wr=0, a_data=0.
  - All DEPTH memory words = 8'h00.
  - Outputs then: PRDATA=0, PREADY=0, PSLVERR=0.
- Reset takes priority over every other event, including a completing write; that write is lost.
- Transfer length = 2 + WAIT_CYCLES cycles (setup + access).
- A read sees data written by any earlier completed write. Write and read of the same address cannot overlap, since only one transfer is active at a time.
- wcnt is 4 bits; it never wraps, because it stops at 0.
- Addresses wrap nowhere: a_addr is used directly, and out-of-range addresses take the error path.

## Structure
- Shared package apb_pkg:
  - state localparams IDLE=3'b001, SETUP=3'b010, ENABLE=3'b100. The ACCESS state uses the SETUP encoding so that bus traces match the bridge.
  - APB_DW=8, APB_AW=9, SLV_AW=8.
- Sub-module apb_mem_array: DEPTH x 8 storage.
  - Synchronous write port and synchronous clear on PRESET.
  - Combinational read port.
- apb_slave_mem holds the FSM, latches, wait counter and error logic.

## Test plan
- Write then read, WAIT_CYCLES=0: write 8'hA5 to addr 8'h10 -> PREADY=1 in the first access cycle, PSLVERR=0. Read 8'h10 -> PRDATA=8'hA5 with PREADY=1.
- Wait states, WAIT_CYCLES=3: read addr 8'h20 after writing 8'h3C -> PREADY low for 3 access cycles and high on the 4th, PRDATA=8'h3C. Transfer length is 5 cycles.
- Out of range, DEPTH=128: write 8'hFF to 8'h90 -> PREADY=1, PSLVERR=1. A later read of 8'h10 (=8'h90 mod 128) returns its prior value, unchanged.
- Protocol error: PSEL=1, PENABLE=1 from IDLE -> PREADY=1, PSLVERR=1 that cycle; a following normal read returns PSLVERR=0.
- Input change: PADDR changes from 8'h05 to 8'h06 between setup and access on a write of 8'h77 -> PSLVERR=1. Both addresses still read 8'h00.
- Reset mid-transfer: PRESET=1 during the second wait cycle of a write, WAIT_CYCLES=3 -> outputs all 0 next cycle. The target address reads 8'h00 after reset.
